data_memory_mc: RTL and testbench
=================================

Name: data_memory_mc

Overview:
Parametrised multi-cycle data memory for the single-cycle/multi-cycle core family.
- Byte-addressed, little-endian, 32-bit words; supports byte, half and word loads/stores with sign/zero extension.
- Valid/ready request channel and a one-cycle response pulse; configurable wait states.
- Misaligned or illegal-size accesses are flagged instead of silently corrupting memory.

Parameters:
ADDR_W, 7, byte-address width; memory holds 2^(ADDR_W-2) 32-bit words (default 32 words).
WAIT_CYCLES, 0, extra cycles between acceptance and response (0..15).

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
req_addr  in  ADDR_W  byte address (ALU result)
req_wdata  in  32  store data, low-aligned (byte in [7:0], half in [15:0])
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  32  extended load data; 0 for stores and faults
resp_fault  out  1  misaligned/illegal access, qualified by resp_valid

Behaviour:
- Reset, sampled at rising edge while rst=1:
  - State goes to IDLE.
  - req_ready=1 once rst deasserts; during rst, req_ready=0.
  - resp_valid=0, resp_rdata=0, resp_fault=0.
  - All memory words cleared to 0x00000000.
  - Reset mid-operation drops the pending request: no write, no response.
- FSM states and transitions:
  - IDLE: req_ready=1. req_valid=1 at edge T → capture we/size/unsigned/addr/wdata. Go to WAIT if WAIT_CYCLES>0, else EXEC.
  - WAIT: counter loads WAIT_CYCLES-1 and decrements each cycle; at 0 → EXEC.
  - EXEC: one cycle; performs the access. Transitions to RESP at the edge ending this cycle.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE.
  - req_ready=0 in WAIT, EXEC and RESP.
- Latency and timing:
  - Request accepted at edge T → resp_valid high in cycle T+2+WAIT_CYCLES.
  - Throughput is one request per 3+WAIT_CYCLES cycles.
- Captured request fields are held internally; input changes after acceptance are ignored.
- Fault rule:
  - Fault when size=11, or size=01 with addr[0]=1, or size=10 with addr[1:0]≠0.
  - On fault: no memory write, resp_rdata=0, resp_fault=1.
- Word index = addr[ADDR_W-1:2]; byte lane = addr[1:0]; half lane = addr[1].
- Store:
  - Only the addressed lanes are written at the EXEC edge; other bytes are preserved.
  - Byte store writes wdata[7:0] to lane addr[1:0]; half store writes wdata[15:0] to bytes {addr[1],0} and {addr[1],1}.
  - resp_rdata=0.
- Load:
  - The word is read in EXEC and the result registered into resp_rdata.
  - Selected lane is right-aligned, then sign- or zero-extended to 32 bits per req_unsigned.
  - req_unsigned is ignored for word loads.
- A load issued after a store to the same address observes the stored data, since the store commits before the next acceptance.
- resp_rdata/resp_fault hold their last values outside RESP; consumers qualify with resp_valid.

Decomposition:
- Package dm_pkg holds:
  - size codes SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - state encoding (IDLE, WAIT, EXEC, RESP);
  - WAIT counter width constant (4).
- One combinational sub-module, dm_load_align: inputs word, lane, size, unsigned → extended 32-bit data. It is reused by the core's load path tests.
- Fault decode is inline in the top module.

Test Plan:
- Reset then word store 0xDEADBEEF @0x04, word load @0x04 (WAIT_CYCLES=0) → resp_valid exactly 2 cycles after acceptance, rdata=0xDEADBEEF, fault=0.
- Byte store 0xAA @0x09 over word 0x11223344 @0x08, then lb @0x09 and lbu @0x09 → word reads 0x1122AA44; lb=0xFFFFFFAA, lbu=0x000000AA.
- Half store 0x8001 @0x0E, then lh @0x0E and lhu @0x0E → lh=0xFFFF8001, lhu=0x00008001; bytes 0x0C/0x0D unchanged.
- lw @0x06, sh @0x03, size=11 @0x00 → each gives resp_fault=1 with rdata=0; memory unchanged after sh.
- WAIT_CYCLES=3: accept at T, toggle req_addr/req_wdata during wait → resp at T+5, original captured values used; req_ready=0 from T+1 to T+5.
- Store accepted, rst asserted in the WAIT cycle → no resp_valid, target word reads 0 after reset, req_ready=1 in the cycle after rst drops.

Source files
------------

// File: rtl/data_memory_mc_pkg.sv
// Shared definitions for the multi-cycle data memory: size codes, FSM states,
// wait-counter width and the store byte-enable decode.
package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_EXEC,
    ST_RESP
  } state_e;

  // Byte lanes touched by a store of the given size at the given lane.
  function automatic logic [3:0] byteEnable(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 4'b0001 << lane;
      SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_mc_load_align.sv
// Load alignment: right-aligns the addressed byte/half of a 32-bit word and
// sign- or zero-extends it; word loads pass through unchanged.
module dm_load_align
  import dm_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;
  logic [15:0] half;

  always_comb begin
    shifted = word_i >> {lane_i, 3'b000};
    half    = lane_i[1] ? word_i[31:16] : word_i[15:0];
    data_o  = 32'h0;
    case (size_i)
      SZ_BYTE: data_o = unsigned_i ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: data_o = unsigned_i ? {16'h0, half} : {{16{half[15]}}, half};
      SZ_WORD: data_o = word_i;
      default: data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_memory_mc.sv
// Multi-cycle byte-addressed data memory with valid/ready request channel,
// configurable wait states, one-cycle response pulse and fault flagging.
module data_memory_mc
  import dm_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault
);

  localparam int DEPTH = 1 << (ADDR_W - 2);

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [31:0] rdata_q;
  logic        fault_q;

  logic [31:0] mem_q [DEPTH];

  logic              fault;
  logic [ADDR_W-3:0] wordIdx;
  logic [31:0]       rdWord;
  logic [31:0]       alignData;
  logic [31:0]       wrLanes;
  logic [3:0]        wrEnable;

  assign fault = (size_q == 2'b11)
              || ((size_q == SZ_HALF) && addr_q[0])
              || ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00));

  assign wordIdx  = addr_q[ADDR_W-1:2];
  assign rdWord   = mem_q[wordIdx];
  assign wrEnable = byteEnable(size_q, addr_q[1:0]);

  always_comb begin
    wrLanes = wdata_q;
    case (size_q)
      SZ_BYTE: wrLanes = {4{wdata_q[7:0]}};
      SZ_HALF: wrLanes = {2{wdata_q[15:0]}};
      default: wrLanes = wdata_q;
    endcase
  end

  dm_load_align u_align (
    .word_i     (rdWord),
    .lane_i     (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (alignData)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_EXEC;
          cnt_d   = WAIT_CNT_W'(WAIT_CYCLES - 1);
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_EXEC;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request fields are frozen at acceptance so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if ((state_q == ST_IDLE) && req_valid) begin
      we_q    <= req_we;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      fault_q <= fault;
      rdata_q <= (fault || we_q) ? 32'h0 : alignData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
    end else if ((state_q == ST_EXEC) && we_q && !fault) begin
      for (int b = 0; b < 4; b++) begin
        if (wrEnable[b]) mem_q[wordIdx][8*b +: 8] <= wrLanes[8*b +: 8];
      end
    end
  end

  assign req_ready  = (state_q == ST_IDLE) && !rst;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_fault = fault_q;

endmodule

// File: tb/tb_data_memory_mc.sv
// Directed bench for data_memory_mc: one instance with no wait states and one
// with three, sharing clock, reset and request fields.
module tb_data_memory_mc;
  import dm_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [6:0]  req_addr;
  logic [31:0] req_wdata;

  logic        valid0, ready0, respValid0, fault0;
  logic [31:0] rdata0;
  logic        valid3, ready3, respValid3, fault3;
  logic [31:0] rdata3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_memory_mc #(.ADDR_W(7), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(valid0), .req_ready(ready0),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(respValid0), .resp_rdata(rdata0), .resp_fault(fault0)
  );

  data_memory_mc #(.ADDR_W(7), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(valid3), .req_ready(ready3),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(respValid3), .resp_rdata(rdata3), .resp_fault(fault3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One full transaction on the selected instance; lat counts falling edges
  // from acceptance to the response pulse, or -1 on timeout.
  task automatic applyStimulus(input int sel, input logic we, input logic [1:0] size,
                               input logic uns, input logic [6:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic fault, output int lat);
    bit rdy;
    rdata = 32'hx;
    fault = 1'bx;
    lat   = -1;
    rdy   = 1'b0;
    for (int i = 0; i < 20 && !rdy; i++) begin
      @(negedge clk);
      rdy = (sel == 0) ? ready0 : ready3;
    end
    if (!rdy) begin
      checkOutput("ready_timeout", 32'(rdy), 32'd1);
      return;
    end
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    if (sel == 0) valid0 = 1'b1; else valid3 = 1'b1;
    @(posedge clk);
    #1;
    valid0 = 1'b0;
    valid3 = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if ((sel == 0) ? respValid0 : respValid3) begin
        lat   = k;
        rdata = (sel == 0) ? rdata0 : rdata3;
        fault = (sel == 0) ? fault0 : fault3;
        break;
      end
    end
    if (lat < 0) checkOutput("resp_timeout", 32'hffffffff, 32'd0);
  endtask

  logic [31:0] rd;
  logic        ft;
  int          lat;
  int          respSeen;
  logic        readyBad;

  initial begin
    rst = 1'b1; valid0 = 1'b0; valid3 = 1'b0;
    req_we = 1'b0; req_size = SZ_WORD; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

    repeat (2) @(negedge clk);
    checkOutput("rst_ready", 32'(ready0), 32'd0);
    checkOutput("rst_resp_valid", 32'(respValid0), 32'd0);
    checkOutput("rst_rdata", rdata0, 32'h0);
    checkOutput("rst_fault", 32'(fault0), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_rst", 32'(ready0), 32'd1);

    applyStimulus(0, 1'b1, SZ_WORD, 1'b0, 7'h04, 32'hDEADBEEF, rd, ft, lat);
    checkOutput("sw_lat", 32'(lat), 32'd2);
    checkOutput("sw_rdata", rd, 32'h0);
    checkOutput("sw_fault", 32'(ft), 32'd0);
    applyStimulus(0, 1'b0, SZ_WORD, 1'b0, 7'h04, 32'h0, rd, ft, lat);
    checkOutput("lw_lat", 32'(lat), 32'd2);
    checkOutput("lw_rdata", rd, 32'hDEADBEEF);
    checkOutput("lw_fault", 32'(ft), 32'd0);
    @(negedge clk);
    checkOutput("resp_one_cycle", 32'(respValid0), 32'd0);
    checkOutput("rdata_held", rdata0, 32'hDEADBEEF);

    applyStimulus(0, 1'b1, SZ_WORD, 1'b0, 7'h08, 32'h11223344, rd, ft, lat);
    applyStimulus(0, 1'b1, SZ_BYTE, 1'b0, 7'h09, 32'h123456AA, rd, ft, lat);
    checkOutput("sb_rdata", rd, 32'h0);
    applyStimulus(0, 1'b0, SZ_WORD, 1'b0, 7'h08, 32'h0, rd, ft, lat);
    checkOutput("sb_word", rd, 32'h1122AA44);
    applyStimulus(0, 1'b0, SZ_BYTE, 1'b0, 7'h09, 32'h0, rd, ft, lat);
    checkOutput("lb_09", rd, 32'hFFFFFFAA);
    applyStimulus(0, 1'b0, SZ_BYTE, 1'b1, 7'h09, 32'h0, rd, ft, lat);
    checkOutput("lbu_09", rd, 32'h000000AA);
    applyStimulus(0, 1'b0, SZ_BYTE, 1'b0, 7'h0B, 32'h0, rd, ft, lat);
    checkOutput("lb_0B", rd, 32'h00000011);

    applyStimulus(0, 1'b1, SZ_WORD, 1'b0, 7'h0C, 32'h55667788, rd, ft, lat);
    applyStimulus(0, 1'b1, SZ_HALF, 1'b0, 7'h0E, 32'hABCD8001, rd, ft, lat);
    checkOutput("sh_fault", 32'(ft), 32'd0);
    applyStimulus(0, 1'b0, SZ_HALF, 1'b0, 7'h0E, 32'h0, rd, ft, lat);
    checkOutput("lh_0E", rd, 32'hFFFF8001);
    applyStimulus(0, 1'b0, SZ_HALF, 1'b1, 7'h0E, 32'h0, rd, ft, lat);
    checkOutput("lhu_0E", rd, 32'h00008001);
    applyStimulus(0, 1'b0, SZ_BYTE, 1'b1, 7'h0C, 32'h0, rd, ft, lat);
    checkOutput("lbu_0C", rd, 32'h00000088);
    applyStimulus(0, 1'b0, SZ_BYTE, 1'b1, 7'h0D, 32'h0, rd, ft, lat);
    checkOutput("lbu_0D", rd, 32'h00000077);
    applyStimulus(0, 1'b0, SZ_HALF, 1'b0, 7'h0C, 32'h0, rd, ft, lat);
    checkOutput("lh_0C", rd, 32'h00007788);
    applyStimulus(0, 1'b0, SZ_WORD, 1'b1, 7'h0C, 32'h0, rd, ft, lat);
    checkOutput("lw_0C_unsigned_ignored", rd, 32'h80017788);

    applyStimulus(0, 1'b0, SZ_WORD, 1'b0, 7'h06, 32'h0, rd, ft, lat);
    checkOutput("lw_06_fault", 32'(ft), 32'd1);
    checkOutput("lw_06_rdata", rd, 32'h0);
    applyStimulus(0, 1'b1, SZ_HALF, 1'b0, 7'h03, 32'h0000FFFF, rd, ft, lat);
    checkOutput("sh_03_fault", 32'(ft), 32'd1);
    checkOutput("sh_03_rdata", rd, 32'h0);
    applyStimulus(0, 1'b1, 2'b11, 1'b0, 7'h00, 32'hFFFFFFFF, rd, ft, lat);
    checkOutput("sz11_fault", 32'(ft), 32'd1);
    checkOutput("sz11_rdata", rd, 32'h0);
    applyStimulus(0, 1'b0, SZ_WORD, 1'b0, 7'h00, 32'h0, rd, ft, lat);
    checkOutput("word0_untouched", rd, 32'h0);
    checkOutput("fault_cleared", 32'(ft), 32'd0);
    applyStimulus(0, 1'b0, SZ_WORD, 1'b0, 7'h04, 32'h0, rd, ft, lat);
    checkOutput("word4_intact", rd, 32'hDEADBEEF);

    // Wait-state instance: fields change during the wait and must be ignored.
    @(negedge clk);
    req_we = 1'b1; req_size = SZ_WORD; req_unsigned = 1'b0; req_addr = 7'h10; req_wdata = 32'hCAFEF00D;
    valid3 = 1'b1;
    @(posedge clk);
    #1;
    valid3 = 1'b0; req_we = 1'b0; req_addr = 7'h14; req_wdata = 32'h0BADBAD0; req_size = SZ_BYTE;
    lat = -1;
    readyBad = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k <= 5 && ready3) readyBad = 1'b1;
      if (respValid3 && lat < 0) lat = k;
    end
    checkOutput("w3_lat", 32'(lat), 32'd5);
    checkOutput("w3_ready_low", 32'(readyBad), 32'd0);
    applyStimulus(1, 1'b0, SZ_WORD, 1'b0, 7'h10, 32'h0, rd, ft, lat);
    checkOutput("w3_lw_lat", 32'(lat), 32'd5);
    checkOutput("w3_captured", rd, 32'hCAFEF00D);
    applyStimulus(1, 1'b0, SZ_WORD, 1'b0, 7'h14, 32'h0, rd, ft, lat);
    checkOutput("w3_other_word", rd, 32'h0);

    // Reset during the wait: the store is dropped with no response.
    applyStimulus(1, 1'b1, SZ_WORD, 1'b0, 7'h18, 32'h12345678, rd, ft, lat);
    @(negedge clk);
    req_we = 1'b1; req_size = SZ_WORD; req_addr = 7'h1C; req_wdata = 32'h12345678;
    valid3 = 1'b1;
    @(posedge clk);
    #1;
    valid3 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_ready", 32'(ready3), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_mid_rst", 32'(ready3), 32'd1);
    respSeen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (respValid3) respSeen++;
    end
    checkOutput("no_resp_after_rst", 32'(respSeen), 32'd0);
    applyStimulus(1, 1'b0, SZ_WORD, 1'b0, 7'h1C, 32'h0, rd, ft, lat);
    checkOutput("dropped_store", rd, 32'h0);
    applyStimulus(1, 1'b0, SZ_WORD, 1'b0, 7'h18, 32'h0, rd, ft, lat);
    checkOutput("mem_cleared_w3", rd, 32'h0);
    applyStimulus(0, 1'b0, SZ_WORD, 1'b0, 7'h04, 32'h0, rd, ft, lat);
    checkOutput("mem_cleared_w0", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
